// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Requests are accepted on req & gnt; rvalid returns data in order, at least one cycle after grant.
interface instr_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads, tracks in-flight PCs and buffers
// returned words in a prefetch FIFO for decode; redirects flush and discard stale responses.
module instr_fetch_unit #(
   parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_req_i,
   input  logic [31:0]        target_addr_i,
   input  logic               target_valid_i,
   output logic [31:0]        instr_o,
   output logic [31:0]        instr_pc_o,
   output logic               instr_valid_o,
   instr_fetch_unit_if.master mem
);
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int FIW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]  outstanding_q, outstanding_d;
   logic [CW-1:0]  discard_q, discard_d;

   logic [31:0]    infl_pc_q [MAX_OUTSTANDING];
   logic [31:0]    infl_pc_d [MAX_OUTSTANDING];
   logic [OIW-1:0] infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;

   logic [31:0]    fifo_instr_q [FIFO_DEPTH];
   logic [31:0]    fifo_instr_d [FIFO_DEPTH];
   logic [31:0]    fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]    fifo_pc_d    [FIFO_DEPTH];
   logic [FIW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;

   logic           issue;
   logic           rsp_keep;
   logic           pop;
   logic [31:0]    level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= BOOT_ADDR;
         outstanding_q <= '0;
         discard_q     <= '0;
         infl_wr_q     <= '0;
         infl_rd_q     <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         fifo_cnt_q    <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) infl_pc_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         infl_wr_q     <= infl_wr_d;
         infl_rd_q     <= infl_rd_d;
         infl_pc_q     <= infl_pc_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_cnt_q    <= fifo_cnt_d;
         fifo_instr_q  <= fifo_instr_d;
         fifo_pc_q     <= fifo_pc_d;
      end
   end

   // Request is gated by reset so the bus is quiet while rst is held.
   always_comb begin
      level         = 32'(fifo_cnt_q) + 32'(outstanding_q);
      mem.req       = !rst && !target_valid_i && (level < 32'(FIFO_DEPTH))
                      && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
      mem.addr      = fetch_pc_q;
      instr_valid_o = (fifo_cnt_q != '0);
      instr_o       = fifo_instr_q[fifo_rd_q];
      instr_pc_o    = fifo_pc_q[fifo_rd_q];
   end

   always_comb begin
      issue         = mem.req && mem.gnt;
      rsp_keep      = mem.rvalid && (discard_q == '0);
      pop           = instr_valid_o && instr_req_i;

      fetch_pc_d    = fetch_pc_q;
      discard_d     = discard_q;
      infl_pc_d     = infl_pc_q;
      infl_wr_d     = infl_wr_q;
      infl_rd_d     = infl_rd_q;
      fifo_instr_d  = fifo_instr_q;
      fifo_pc_d     = fifo_pc_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_rd_d     = fifo_rd_q;

      if (issue) begin
         infl_pc_d[infl_wr_q] = fetch_pc_q;
         infl_wr_d  = (infl_wr_q == OIW'(MAX_OUTSTANDING - 1)) ? '0 : infl_wr_q + 1'b1;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (mem.rvalid) begin
         infl_rd_d = (infl_rd_q == OIW'(MAX_OUTSTANDING - 1)) ? '0 : infl_rd_q + 1'b1;
         if (discard_q != '0) discard_d = discard_q - 1'b1;
      end

      if (rsp_keep) begin
         fifo_instr_d[fifo_wr_q] = mem.rdata;
         fifo_pc_d[fifo_wr_q]    = infl_pc_q[infl_rd_q];
         fifo_wr_d = (fifo_wr_q == FIW'(FIFO_DEPTH - 1)) ? '0 : fifo_wr_q + 1'b1;
      end

      if (pop) fifo_rd_d = (fifo_rd_q == FIW'(FIFO_DEPTH - 1)) ? '0 : fifo_rd_q + 1'b1;

      outstanding_d = outstanding_q + CW'(issue) - CW'(mem.rvalid);
      fifo_cnt_d    = fifo_cnt_q + FCW'(rsp_keep) - FCW'(pop);

      // Redirect: everything still in flight is stale, including a response landing this cycle.
      if (target_valid_i) begin
         fetch_pc_d = {target_addr_i[31:2], 2'b00};
         discard_d  = outstanding_q - CW'(mem.rvalid);
         fifo_cnt_d = '0;
         fifo_wr_d  = '0;
         fifo_rd_d  = '0;
      end
   end

   a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (rst)
      mem.rvalid |-> (outstanding_q != '0));
   a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
      32'(outstanding_q) <= 32'(MAX_OUTSTANDING));
   a_discard_bound: assert property (@(posedge clk) disable iff (rst)
      discard_q <= outstanding_q);
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      rsp_keep |-> (32'(fifo_cnt_q) < 32'(FIFO_DEPTH) || pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-based reference model of the fetch stage
// and an in-order instruction memory with random grant and response latency.
module tb_instr_fetch_unit;
   localparam logic [31:0] BOOT = 32'h0000_0000;
   localparam int          FD   = 2;
   localparam int          MO   = 2;
   localparam logic [31:0] SALT = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i;
   logic [31:0] target_addr_i;
   logic        target_valid_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;

   instr_fetch_unit_if mem_if ();

   instr_fetch_unit #(
      .BOOT_ADDR       (BOOT),
      .FIFO_DEPTH      (FD),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .target_addr_i  (target_addr_i),
      .target_valid_i (target_valid_i),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .instr_valid_o  (instr_valid_o),
      .mem            (mem_if.master)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; bit disc; int rdy; } infl_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

   infl_t       infl_m[$];
   ent_t        fifo_m[$];
   logic [31:0] pc_m;
   int          cyc;
   int          lat;
   int          errors;
   int          checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      infl_m.delete();
      fifo_m.delete();
      pc_m = BOOT;
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", instr_pc_o, 32'd0);
      chk("rst_req", {31'b0, mem_if.req}, 32'd0);
      chk("rst_addr", mem_if.addr, BOOT);
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input bit tv, input logic [31:0] ta, input bit dreq,
                       input bit gnt, input bit rv_try);
      bit    rv;
      bit    exp_req;
      bit    exp_valid;
      infl_t f;
      rv = 1'b0;
      if (rv_try && infl_m.size() > 0) rv = (infl_m[0].rdy <= cyc);
      target_valid_i   = tv;
      target_addr_i    = ta;
      instr_req_i      = dreq;
      mem_if.gnt       = gnt;
      mem_if.rvalid    = rv;
      mem_if.rdata     = rv ? (infl_m[0].pc ^ SALT) : $urandom;
      exp_valid = (fifo_m.size() != 0);
      exp_req   = !tv && (fifo_m.size() + infl_m.size() < FD) && (infl_m.size() < MO);
      @(negedge clk);
      chk("valid", {31'b0, instr_valid_o}, {31'b0, exp_valid});
      if (exp_valid) begin
         chk("instr", instr_o, fifo_m[0].data);
         chk("instr_pc", instr_pc_o, fifo_m[0].pc);
      end
      chk("req", {31'b0, mem_if.req}, {31'b0, exp_req});
      chk("addr", mem_if.addr, pc_m);
      if (exp_valid && dreq && !tv) void'(fifo_m.pop_front());
      if (rv) begin
         f = infl_m.pop_front();
         if (!f.disc) fifo_m.push_back('{f.pc ^ SALT, f.pc});
      end
      if (tv) begin
         fifo_m.delete();
         foreach (infl_m[i]) infl_m[i].disc = 1'b1;
         pc_m = {ta[31:2], 2'b00};
      end
      if (exp_req && gnt) begin
         infl_m.push_back('{pc_m, 1'b0, cyc + 1 + $urandom_range(0, lat)});
         pc_m = pc_m + 32'd4;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      lat    = 0;
      rst            = 1'b1;
      instr_req_i    = 1'b0;
      target_addr_i  = '0;
      target_valid_i = 1'b0;
      mem_if.gnt     = 1'b0;
      mem_if.rvalid  = 1'b0;
      mem_if.rdata   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Zero-wait memory, decode always ready.
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Decode stall fills the buffer, then release.
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Slow grants and responses.
      lat = 2;
      for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, ($urandom % 4) == 0, 1'b1);

      // Redirect with two requests in flight to a misaligned target.
      lat = 0;
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Redirect coinciding with a response and a decode pop.
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Fetch PC wrap past the top of the address space.
      step(1'b1, 32'hFFFF_FFF6, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      // Fully random traffic.
      for (int i = 0; i < 1500; i++) begin
         if ((i % 100) == 0) lat = $urandom_range(0, 3);
         step(($urandom % 12) == 0, $urandom, ($urandom % 3) != 0,
              ($urandom % 2) == 0, ($urandom % 3) != 0);
      end

      // Reset while requests are outstanding.
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      rst            = 1'b1;
      target_valid_i = 1'b0;
      instr_req_i    = 1'b0;
      mem_if.gnt     = 1'b0;
      mem_if.rvalid  = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
